// File: rtl/encrypt_mcpu.sv
// Generic FIFO: single-clock circular buffer, DEPTH a power of two.
// Latency: a pushed entry is visible at pop_dat on the edge after the push.
// Backpressure: pushes are dropped while full, pops are ignored while empty.
module encrypt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && !empty;
    assign pop_dat = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Main-CPU opcode encryptor: buffers plain bytes and writes them encrypted to memory.
// Latency: a byte pushed into an idle, empty block reaches wr_req two edges later.
// Backpressure: in_ready drops while the FIFO is full; the write holds until wr_ack.
module encrypt_mcpu #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  encryption,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_addr,
    input  logic [7:0]  in_data,
    output logic        wr_req,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ack,
    output logic [15:0] bytes_written
);
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  dat;
    } entry_t;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t state_q, state_d;
    entry_t push_entry;
    entry_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   ready_en;
    logic   push;
    logic   load;
    logic   ack_req;
    logic [7:0] enc_dat;

    // Encryption is applied before buffering so later scheme changes cannot touch queued bytes.
    always_comb begin
        enc_dat = in_data;
        if (encryption == 8'd1 || encryption == 8'd2) begin
            enc_dat[6:1] = {in_data[2], in_data[5], in_data[1], in_data[3], in_data[6], in_data[4]};
            if (!in_addr[13]) begin
                enc_dat[7] = ~in_data[7];
                enc_dat[0] = ~in_data[0];
            end else if (!in_addr[2]) begin
                enc_dat[7] = ~in_data[0];
                enc_dat[0] = ~in_data[7];
            end else begin
                enc_dat[7] = in_data[0];
                enc_dat[0] = in_data[7];
            end
        end
    end

    assign push_entry = '{addr: in_addr, dat: enc_dat};
    assign in_ready   = ready_en && !fifo_full;
    assign push       = in_valid && in_ready;

    encrypt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (push),
        .push_dat (push_entry),
        .pop_rdy  (load),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty)          state_d = S_REQ;
            S_REQ:   if (wr_ack && fifo_empty) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A load is also the FIFO pop; acks seen in IDLE are ignored.
    always_comb begin
        ack_req = (state_q == S_REQ) && wr_ack;
        load    = !fifo_empty && ((state_q == S_IDLE) || ack_req);
    end

    assign wr_req = (state_q == S_REQ);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_addr       <= '0;
            wr_data       <= '0;
            bytes_written <= '0;
            ready_en      <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (load) begin
                wr_addr <= head.addr;
                wr_data <= head.dat;
            end
            if (ack_req) bytes_written <= bytes_written + 16'd1;
        end
    end
endmodule

// File: tb/tb_encrypt_mcpu.sv
// Self-checking bench for encrypt_mcpu: directed phases plus random traffic against a scoreboard model.
module tb_encrypt_mcpu;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic [7:0]  encryption;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_addr;
    logic [7:0]  in_data;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [15:0] bytes_written;

    encrypt_mcpu #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .encryption    (encryption),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .bytes_written (bytes_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  plain;
        logic [7:0]  scheme;
    } sb_t;

    sb_t         sb_q[$];
    logic [7:0]  wlog[$];
    logic [15:0] alog[$];
    logic [15:0] bw_exp;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_push;

    function automatic logic [7:0] enc_model(logic [7:0] d, logic [15:0] a, logic [7:0] s);
        int   src [8] = '{0, 4, 6, 3, 1, 5, 2, 7};
        logic inv [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] e;
        if (s != 8'd1 && s != 8'd2) return d;
        if (a[13]) begin
            src[0] = 7;
            src[7] = 0;
            if (a[2]) begin
                inv[0] = 1'b0;
                inv[7] = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) e[i] = d[src[i]] ^ inv[i];
        return e;
    endfunction

    // Main-CPU decrypt: inverse of the bit permutation and inversion above.
    function automatic logic [7:0] dec_model(logic [7:0] e, logic [15:0] a);
        logic [7:0] p;
        p[2] = e[6]; p[5] = e[5]; p[1] = e[4]; p[3] = e[3]; p[6] = e[2]; p[4] = e[1];
        if (!a[13])     begin p[7] = ~e[7]; p[0] = ~e[0]; end
        else if (!a[2]) begin p[0] = ~e[7]; p[7] = ~e[0]; end
        else            begin p[0] = e[7];  p[7] = e[0];  end
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scores the handshakes seen just before the next edge, then advances one cycle.
    task automatic tick();
        sb_t e;
        if (reset_n && wr_req && wr_ack) begin
            wlog.push_back(wr_data);
            alog.push_back(wr_addr);
            if (sb_q.size() == 0) begin
                check("unexpected_write", 32'(sb_q.size()), 1);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, enc_model(e.plain, e.addr, e.scheme));
                if (e.scheme == 8'd1 || e.scheme == 8'd2)
                    check("roundtrip", dec_model(wr_data, wr_addr), e.plain);
            end
            bw_exp = bw_exp + 16'd1;
        end
        if (reset_n && in_valid && in_ready) begin
            e.addr   = in_addr;
            e.plain  = in_data;
            e.scheme = encryption;
            sb_q.push_back(e);
            n_push++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        for (int k = 0; k < cycles; k++) tick();
        reset_n = 1'b1;
        sb_q.delete();
        bw_exp = 16'd0;
        n_push = 0;
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        logic accepted;
        accepted = 1'b0;
        in_addr  = a;
        in_data  = d;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            accepted = in_ready;
            tick();
            if (accepted) break;
        end
        if (!accepted) check("push_timeout", 32'(accepted), 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        wr_ack   = 1'b1;
        for (int k = 0; k < 5000; k++) begin
            if (sb_q.size() == 0) break;
            tick();
        end
        check("drain_done", 32'(sb_q.size()), 0);
        wr_ack = 1'b0;
        tick();
        check("idle_after_drain", wr_req, 0);
        check("bytes_written", bytes_written, bw_exp);
    endtask

    initial begin
        int          n_acc;
        logic [15:0] ra [3] = '{16'h0000, 16'h2000, 16'h2004};

        reset_n = 1'b0; encryption = 8'd0; in_valid = 1'b0;
        in_addr = '0; in_data = '0; wr_ack = 1'b0; bw_exp = '0; n_push = 0;

        // Reset state and release
        do_reset(3);
        reset_n = 1'b0;
        tick();
        check("rst_wr_req", wr_req, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_bytes", bytes_written, 0);
        check("rst_in_ready", in_ready, 0);
        reset_n = 1'b1;
        tick();
        check("ready_after_release", in_ready, 1);

        // wr_ack in IDLE must not count
        wr_ack = 1'b1;
        repeat (3) tick();
        check("idle_ack_ignored", bytes_written, 0);
        wr_ack = 1'b0;

        // Two-edge latency from push to wr_req
        encryption = 8'd1;
        in_addr = 16'h1234; in_data = 8'h5A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_edge1", wr_req, 0);
        tick();
        check("lat_edge2", wr_req, 1);
        check("lat_addr", wr_addr, 16'h1234);
        drain();

        // Directed scheme-1 vectors with wr_ack tied high
        wlog.delete(); alog.delete();
        wr_ack = 1'b1;
        push(16'h0000, 8'h00);
        push(16'h2000, 8'h01);
        push(16'h2004, 8'h80);
        push(16'h2004, 8'h04);
        drain();
        check("vec_n", 32'(wlog.size()), 4);
        if (wlog.size() == 4) begin
            check("vec0", wlog[0], 8'h81); check("vec0_a", alog[0], 16'h0000);
            check("vec1", wlog[1], 8'h01); check("vec1_a", alog[1], 16'h2000);
            check("vec2", wlog[2], 8'h01); check("vec2_a", alog[2], 16'h2004);
            check("vec3", wlog[3], 8'h40); check("vec3_a", alog[3], 16'h2004);
        end

        // Pass-through schemes
        wlog.delete();
        encryption = 8'd0;    push(16'h2000, 8'hA5);
        encryption = 8'h55;   push(16'h2000, 8'hA5);
        drain();
        check("plain_n", 32'(wlog.size()), 2);
        if (wlog.size() == 2) begin
            check("plain_0", wlog[0], 8'hA5);
            check("plain_55", wlog[1], 8'hA5);
        end

        // Round trip over every byte, scheme and address class
        wr_ack = 1'b1;
        for (int s = 1; s <= 2; s++)
            for (int ai = 0; ai < 3; ai++)
                for (int d = 0; d < 256; d++) begin
                    encryption = 8'(s);
                    push(ra[ai], 8'(d));
                end
        drain();

        // Fill with wr_ack low, then push/pop interplay at full and full-1
        wr_ack = 1'b0; in_valid = 1'b1; n_acc = 0;
        for (int k = 0; k < 40; k++) begin
            encryption = 8'($urandom_range(0, 3));
            in_data = 8'($urandom); in_addr = 16'($urandom);
            if (!in_ready) break;
            n_acc++;
            tick();
        end
        check("fill_accepted", 32'(n_acc), 32'(DEPTH + 1));
        check("full_ready", in_ready, 0);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("ready_after_pop", in_ready, 1);
        tick();
        check("full_again", in_ready, 0);
        wr_ack = 1'b1; in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 8'($urandom); in_addr = 16'($urandom);
        tick();
        check("pushpop_dm1", in_ready, 1);
        wr_ack = 1'b0; in_data = 8'($urandom); in_addr = 16'($urandom);
        tick();
        check("refill_full", in_ready, 0);
        drain();

        // Random traffic: scheme changes while buffered, random acks
        for (int k = 0; k < 800; k++) begin
            case ($urandom_range(0, 3))
                0: encryption = 8'd1;
                1: encryption = 8'd2;
                2: encryption = 8'd0;
                default: encryption = 8'($urandom);
            endcase
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            in_addr  = 16'($urandom);
            wr_ack   = 1'($urandom);
            tick();
        end
        drain();

        // Reset while in REQ with three entries buffered
        wr_ack = 1'b0;
        for (int k = 0; k < 4; k++) push(16'($urandom), 8'($urandom));
        tick();
        check("pre_rst_req", wr_req, 1);
        do_reset(1);
        check("mid_rst_req", wr_req, 0);
        check("mid_rst_bytes", bytes_written, 0);
        wr_ack = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("no_stale_write", 32'(wlog.size() == 0 ? 0 : 0) + 32'(bytes_written), 0);
        check("post_rst_idle", wr_req, 0);
        wr_ack = 1'b0;

        // bytes_written wrap
        wr_ack = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            if (n_push >= 65535) break;
            encryption = 8'($urandom_range(0, 2));
            in_data = 8'($urandom); in_addr = 16'($urandom);
            tick();
        end
        drain();
        check("bw_ffff", bytes_written, 16'hFFFF);
        push(16'h2004, 8'h3C);
        drain();
        check("bw_wrap", bytes_written, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/encrypt_mcpu.md
ENCRYPT_MCPU -- requirements
Module: encrypt_mcpu

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, input buffer depth in entries; legal values are powers of two, 2 to 16.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port encryption  input  8  scheme select: 0 = none, 1 and 2 = main-CPU opcode scheme, others = none.
REQ-005 SHALL have port in_valid  input  1  plain byte offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a byte.
REQ-007 SHALL have port in_addr  input  16  CPU address of the offered byte.
REQ-008 SHALL have port in_data  input  8  plain (decrypted) byte.
REQ-009 SHALL have port wr_req  output  1  memory write request, held until acknowledged.
REQ-010 SHALL have port wr_addr  output  16  write address; equals the in_addr of that byte.
REQ-011 SHALL have port wr_data  output  8  encrypted byte.
REQ-012 SHALL have port wr_ack  input  1  memory accepted the current write.
REQ-013 SHALL have port bytes_written  output  16  count of acknowledged writes.

Function
REQ-014 SHALL push {in_addr, E(in_data)} into the FIFO on any cycle where in_valid and in_ready are both 1 ("push").
REQ-015 SHALL compute E from the encryption value sampled on the push cycle; a later change of encryption SHALL NOT affect entries already buffered.
REQ-016 For schemes 1 and 2, encrypted bits 6..1 SHALL be {d2, d5, d1, d3, d6, d4}, where d is the plain byte.
REQ-017 For schemes 1 and 2 with addr[13]=0, encrypted bit 7 SHALL be ~d7 and bit 0 SHALL be ~d0.
REQ-018 For schemes 1 and 2 with addr[13]=1 and addr[2]=0, encrypted bit 7 SHALL be ~d0 and bit 0 SHALL be ~d7.
REQ-019 For schemes 1 and 2 with addr[13]=1 and addr[2]=1, encrypted bit 7 SHALL be d0 and bit 0 SHALL be d7.
REQ-020 For all other schemes, E(d) SHALL equal d.
REQ-021 SHALL drive in_ready = 1 exactly when the FIFO is not full (registered count < FIFO_DEPTH); there is no bypass path.
REQ-022 SHALL allow a push and a pop in the same cycle; the occupancy count SHALL then stay unchanged, including when occupancy is FIFO_DEPTH-1.
REQ-023 Write FSM SHALL have two states, IDLE and REQ, and register wr_req, wr_addr and wr_data.
REQ-024 In IDLE with the FIFO non-empty, the FSM SHALL load the FIFO head into wr_addr/wr_data, pop it, set wr_req = 1, and go to REQ.
REQ-025 In REQ, wr_req, wr_addr and wr_data SHALL hold stable until wr_ack = 1.
REQ-026 In REQ on wr_ack with the FIFO non-empty, the FSM SHALL load and pop the next entry, keep wr_req = 1, and stay in REQ (back-to-back writes, no bubble).
REQ-027 In REQ on wr_ack with the FIFO empty, the FSM SHALL clear wr_req and go to IDLE.
REQ-028 An entry pushed into an empty FIFO while in IDLE SHALL appear on wr_req 2 cycles after the push edge (push edge, then load edge).
REQ-029 SHALL ignore wr_ack while in IDLE.
REQ-030 SHALL increment bytes_written by 1 on each wr_ack in REQ; it is 16-bit and SHALL wrap from 0xFFFF to 0x0000.
REQ-031 SHALL pop the FIFO only via the FSM and SHALL never underflow; FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-032 While reset_n = 0 at a clock edge, the block SHALL: empty the FIFO, enter IDLE, set wr_req = 0, wr_addr = 0, wr_data = 0, bytes_written = 0, and in_ready = 0.
REQ-033 in_ready SHALL go to 1 on the first edge after reset_n returns to 1.
REQ-034 A reset during REQ SHALL discard the pending write and all buffered entries without issuing further requests.

Verification
REQ-035 encryption=1; push addr=0x0000 data=0x00, then addr=0x2000 data=0x01, then addr=0x2004 data=0x80, then addr=0x2004 data=0x04, with wr_ack tied high -> wr_data sequence 0x81, 0x01, 0x01, 0x40 with matching wr_addr; bytes_written = 4.
REQ-036 encryption=0 and encryption=0x55; push 0xA5 at addr 0x2000 -> wr_data = 0xA5 in both cases.
REQ-037 Round trip: all 256 data values at addresses 0x0000, 0x2000 and 0x2004, schemes 1 and 2, fed through the main-CPU decrypt function -> original byte recovered every time.
REQ-038 wr_ack held low; push until in_ready = 0 -> exactly FIFO_DEPTH entries buffered plus one held on wr_req; then pulse wr_ack while pushing in the same cycle -> occupancy stays FIFO_DEPTH, ordering preserved.
REQ-039 Assert reset_n = 0 for one cycle while in REQ with 3 entries buffered -> wr_req = 0 and bytes_written = 0 next cycle; no stale write appears after release.
REQ-040 Preload bytes_written to 0xFFFF by 65535 writes, then one more acknowledged write -> bytes_written = 0x0000.
